// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling ratio and
// the baud divisor rounding used by both receiver and transmitter.
package uart_pkg;

   localparam int unsigned OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } rx_state_t;

   // Clock cycles per oversample tick, rounded to nearest.
   function automatic int unsigned baud_div(input int unsigned clk_freq,
                                            input int unsigned baud);
      return (clk_freq + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle o_tick every DIV clocks, restartable
// by i_clear so the bit grid aligns to a detected start edge.
module uart_baud_tick #(
   parameter int unsigned DIV = 65
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clear,
   output logic o_tick
);

   localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;

   // Free-running modulo-DIV counter, restarted on start detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (i_clear)
         r_cnt <= '0;
      else if (r_cnt == LAST)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + 1'b1;
   end

   assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_os16.sv
// 16x oversampling UART receiver with 3-sample majority vote per bit,
// framing-error and line-break reporting.
module uart_rx_os16 #(
   parameter int unsigned CLK_FREQ   = 10_000_000,
   parameter int unsigned BAUD       = 9600,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_frame_err,
   output logic       o_break,
   output logic       o_busy
);

   import uart_pkg::*;

   localparam int unsigned DIV      = baud_div(CLK_FREQ, BAUD);
   localparam logic [3:0]  SMP_LAST = 4'(OVERSAMPLE - 1);
   localparam logic [3:0]  SMP_C7   = 4'd7;
   localparam logic [3:0]  SMP_C8   = 4'd8;
   localparam logic [3:0]  SMP_VOTE = 4'd9;

   logic       r_sync1, r_sync2, r_rx_prev;
   logic       w_rx_s, w_fall, w_start, w_tick;
   logic       w_at_vote, w_at_end, w_vote;
   logic [3:0] r_smp;
   logic [2:0] r_bit_idx;
   logic       r_c7, r_c8;
   logic [7:0] r_shift, r_data;
   logic       r_valid, r_ferr, r_brk;
   rx_state_t  r_state, w_state_nxt;
   logic       w_shift_en, w_bit_inc, w_bit_clr;
   logic       w_set_valid, w_set_ferr, w_set_brk;

   // Two-flop synchronizer plus edge history; all reset high (idle line).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_sync1   <= i_rx;
         r_sync2   <= r_sync1;
         r_rx_prev <= r_sync2;
      end
   end

   assign w_rx_s  = r_sync2;
   assign w_fall  = r_rx_prev & ~w_rx_s;
   assign w_start = (r_state == IDLE) & w_fall;

   uart_baud_tick #(
      .DIV(DIV)
   ) u_baud_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clear(w_start),
      .o_tick (w_tick)
   );

   // Sample position within the current bit period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_smp <= '0;
      else if (w_start)
         r_smp <= '0;
      else if (w_tick)
         r_smp <= (r_smp == SMP_LAST) ? 4'd0 : r_smp + 4'd1;
   end

   // Capture the first two vote samples; the third is taken live at sample 9.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_c7 <= 1'b1;
         r_c8 <= 1'b1;
      end else if (w_tick) begin
         if (r_smp == SMP_C7) r_c7 <= w_rx_s;
         if (r_smp == SMP_C8) r_c8 <= w_rx_s;
      end
   end

   assign w_vote    = (r_c7 & r_c8) | (r_c7 & w_rx_s) | (r_c8 & w_rx_s);
   assign w_at_vote = w_tick & (r_smp == SMP_VOTE);
   assign w_at_end  = w_tick & (r_smp == SMP_LAST);

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next-state and datapath control decode.
   always_comb begin
      w_state_nxt = r_state;
      w_shift_en  = 1'b0;
      w_bit_inc   = 1'b0;
      w_bit_clr   = 1'b0;
      w_set_valid = 1'b0;
      w_set_ferr  = 1'b0;
      w_set_brk   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_fall) w_state_nxt = START;
         end
         START: begin
            if (w_at_vote && w_vote) begin
               w_state_nxt = IDLE;
            end else if (w_at_end) begin
               w_state_nxt = DATA;
               w_bit_clr   = 1'b1;
            end
         end
         DATA: begin
            if (w_at_vote) w_shift_en = 1'b1;
            if (w_at_end) begin
               if (r_bit_idx == 3'd7) w_state_nxt = STOP;
               else                   w_bit_inc   = 1'b1;
            end
         end
         STOP: begin
            if (w_at_vote) begin
               if (w_vote) begin
                  w_set_valid = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_set_ferr  = 1'b1;
                  w_set_brk   = (r_shift == 8'h00);
                  w_state_nxt = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            if (w_rx_s) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Bit index, shift register, output byte and single-cycle status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_ferr    <= 1'b0;
         r_brk     <= 1'b0;
      end else begin
         if (w_bit_clr)
            r_bit_idx <= '0;
         else if (w_bit_inc)
            r_bit_idx <= r_bit_idx + 3'd1;
         if (w_shift_en)
            r_shift <= {w_vote, r_shift[7:1]};
         if (w_set_valid || w_set_ferr)
            r_data <= r_shift;
         r_valid <= w_set_valid;
         r_ferr  <= w_set_ferr;
         r_brk   <= w_set_brk;
      end
   end

   assign o_data      = r_data;
   assign o_valid     = r_valid;
   assign o_frame_err = r_ferr;
   assign o_break     = r_brk;
   assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16: directed scenarios plus random
// frames, checked against a frame-level expectation queue.
module tb_uart_rx_os16;

   // Reduced clock keeps the run short; 2.1 MHz / (9600*16) = 13.67, rounds to 14.
   localparam int unsigned TB_CLK  = 2_100_000;
   localparam int unsigned TB_BAUD = 9600;
   localparam int unsigned DIV_TB  = (TB_CLK + TB_BAUD * 8) / (TB_BAUD * 16);
   localparam int unsigned BIT     = DIV_TB * 16;
   localparam int unsigned LAT     = 2 + 154 * DIV_TB + 1;
   localparam int unsigned GLITCH  = TB_CLK / 50_000;
   localparam int unsigned SPK_OFS = 8 * DIV_TB + DIV_TB / 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       i_rx;
   logic [7:0] o_data;
   logic       o_valid, o_frame_err, o_break, o_busy;

   typedef struct {
      logic        valid;
      logic        ferr;
      logic        brk;
      logic [7:0]  data;
      int unsigned cyc;
   } ev_t;

   ev_t         evq[$];
   ev_t         expq[$];
   int unsigned cyc = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   uart_rx_os16 #(
      .CLK_FREQ  (TB_CLK),
      .BAUD      (TB_BAUD),
      .OVERSAMPLE(16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_rx       (i_rx),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .o_frame_err(o_frame_err),
      .o_break    (o_break),
      .o_busy     (o_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Record every status pulse and check flag exclusivity as it happens.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && (o_valid || o_frame_err || o_break)) begin
         ev_t e;
         e.valid = o_valid;
         e.ferr  = o_frame_err;
         e.brk   = o_break;
         e.data  = o_data;
         e.cyc   = cyc;
         evq.push_back(e);
         chk("valid_vs_ferr", 32'(o_valid & o_frame_err), 32'd0);
         chk("brk_needs_ferr", 32'(o_break & ~o_frame_err), 32'd0);
      end
   end

   task automatic wait_cyc(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   // Reference: a frame yields data on a good stop bit, else a framing error
   // (with break when the byte is all zeros); o_data follows the byte either way.
   task automatic exp_frame(input logic [7:0] b, input logic stop_v);
      ev_t e;
      e.valid = stop_v;
      e.ferr  = ~stop_v;
      e.brk   = ~stop_v && (b == 8'h00);
      e.data  = b;
      e.cyc   = 0;
      expq.push_back(e);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_v,
                             input int spike_bit, output int unsigned t0);
      i_rx = 1'b0;
      t0   = cyc;
      wait_cyc(BIT);
      for (int i = 0; i < 8; i++) begin
         i_rx = b[i];
         if (i == spike_bit) begin
            wait_cyc(SPK_OFS);
            i_rx = ~b[i];
            wait_cyc(DIV_TB);
            i_rx = b[i];
            wait_cyc(BIT - SPK_OFS - DIV_TB);
         end else begin
            wait_cyc(BIT);
         end
      end
      i_rx = stop_v;
      wait_cyc(BIT);
   endtask

   task automatic expect_frames(input string tag);
      int n;
      chk({tag, "_count"}, 32'(evq.size()), 32'(expq.size()));
      n = (evq.size() < expq.size()) ? evq.size() : expq.size();
      for (int i = 0; i < n; i++) begin
         chk({tag, "_valid"}, 32'(evq[i].valid), 32'(expq[i].valid));
         chk({tag, "_ferr"},  32'(evq[i].ferr),  32'(expq[i].ferr));
         chk({tag, "_brk"},   32'(evq[i].brk),   32'(expq[i].brk));
         chk({tag, "_data"},  32'(evq[i].data),  32'(expq[i].data));
      end
      evq.delete();
      expq.delete();
   endtask

   initial begin
      repeat (200_000) @(posedge clk);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned t0;
      logic [7:0]  b;
      logic        sv;
      logic [7:0]  third;

      rst_n = 1'b0;
      i_rx  = 1'b1;
      wait_cyc(5);
      chk("rst_data",  32'(o_data),      32'd0);
      chk("rst_valid", 32'(o_valid),     32'd0);
      chk("rst_ferr",  32'(o_frame_err), 32'd0);
      chk("rst_brk",   32'(o_break),     32'd0);
      chk("rst_busy",  32'(o_busy),      32'd0);
      rst_n = 1'b1;
      wait_cyc(BIT);

      // Clean byte with latency check.
      exp_frame(8'h61, 1'b1);
      send_frame(8'h61, 1'b1, -1, t0);
      wait_cyc(BIT);
      chk("clean_latency", (evq.size() > 0) ? evq[0].cyc - t0 : 32'd0, LAT);
      expect_frames("clean");

      // Start-bit glitch.
      i_rx = 1'b0;
      wait_cyc(5);
      chk("glitch_busy_hi", 32'(o_busy), 32'd1);
      wait_cyc(GLITCH - 5);
      i_rx = 1'b1;
      wait_cyc(200 - GLITCH);
      chk("glitch_busy_lo", 32'(o_busy), 32'd0);
      wait_cyc(BIT);
      expect_frames("glitch");

      // Framing error, line held low, then a good byte.
      exp_frame(8'h55, 1'b0);
      send_frame(8'h55, 1'b0, -1, t0);
      wait_cyc(3 * BIT);
      chk("ferr_wait_busy", 32'(o_busy), 32'd1);
      i_rx = 1'b1;
      wait_cyc(BIT);
      chk("ferr_idle_busy", 32'(o_busy), 32'd0);
      exp_frame(8'h41, 1'b1);
      send_frame(8'h41, 1'b1, -1, t0);
      wait_cyc(BIT);
      expect_frames("ferr");
      chk("ferr_data_hold", 32'(o_data), 32'h41);

      // Break: 20 bit times low.
      exp_frame(8'h00, 1'b0);
      i_rx = 1'b0;
      wait_cyc(20 * BIT);
      chk("brk_wait_busy", 32'(o_busy), 32'd1);
      i_rx = 1'b1;
      wait_cyc(2 * BIT);
      expect_frames("brk");
      chk("brk_data", 32'(o_data), 32'h00);
      chk("brk_idle_busy", 32'(o_busy), 32'd0);

      // Noise spike at sample 8 of data bit 3.
      exp_frame(8'h00, 1'b1);
      send_frame(8'h00, 1'b1, 3, t0);
      wait_cyc(BIT);
      expect_frames("noise");

      // Back-to-back frames.
      exp_frame(8'h7A, 1'b1);
      exp_frame(8'h5A, 1'b1);
      send_frame(8'h7A, 1'b1, -1, t0);
      send_frame(8'h5A, 1'b1, -1, t0);
      wait_cyc(BIT);
      expect_frames("b2b");
      chk("b2b_data", 32'(o_data), 32'h5A);

      // Reset in data bit 4 of a third frame.
      third = 8'hC3;
      i_rx = 1'b0;
      wait_cyc(BIT);
      for (int i = 0; i < 4; i++) begin
         i_rx = third[i];
         wait_cyc(BIT);
      end
      i_rx = third[4];
      wait_cyc(BIT / 2);
      rst_n = 1'b0;
      #1;
      chk("mrst_data",  32'(o_data),      32'd0);
      chk("mrst_valid", 32'(o_valid),     32'd0);
      chk("mrst_ferr",  32'(o_frame_err), 32'd0);
      chk("mrst_busy",  32'(o_busy),      32'd0);
      i_rx = 1'b1;
      wait_cyc(10);
      rst_n = 1'b1;
      wait_cyc(2 * BIT);
      exp_frame(8'h33, 1'b1);
      send_frame(8'h33, 1'b1, -1, t0);
      wait_cyc(BIT);
      expect_frames("after_rst");

      // Random frames with random stop validity, gaps and low holds.
      for (int k = 0; k < 16; k++) begin
         b  = 8'($urandom);
         if ($urandom_range(0, 5) == 0) b = 8'h00;
         sv = ($urandom_range(0, 3) != 0);
         exp_frame(b, sv);
         send_frame(b, sv, -1, t0);
         if (!sv) begin
            wait_cyc($urandom_range(0, 2 * BIT));
            i_rx = 1'b1;
            wait_cyc($urandom_range(4, BIT));
         end else begin
            i_rx = 1'b1;
            wait_cyc($urandom_range(0, BIT));
         end
      end
      i_rx = 1'b1;
      wait_cyc(2 * BIT);
      expect_frames("rand");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
